// File: rtl/bpu_if.sv
// bpu_if: fetch lookup, ID resolution and redirect signals between the core and branch_predict_unit.
interface bpu_if;
    logic [63:0] if_pc;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        id_valid;
    logic        id_stall;
    logic        id_is_branch;
    logic        id_is_jal;
    logic [63:0] id_pc;
    logic        id_pred_taken;
    logic [63:0] id_pred_target;
    logic        br_taken;
    logic [63:0] br_target;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mispred_count;
    modport master (
        output if_pc, id_valid, id_stall, id_is_branch, id_is_jal, id_pc,
               id_pred_taken, id_pred_target, br_taken, br_target,
        input  pred_taken, pred_target, redirect, redirect_pc, br_count, mispred_count
    );
    modport slave (
        input  if_pc, id_valid, id_stall, id_is_branch, id_is_jal, id_pc,
               id_pred_taken, id_pred_target, br_taken, br_target,
        output pred_taken, pred_target, redirect, redirect_pc, br_count, mispred_count
    );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: 2-bit counter direction predictor with tagged BTB and ID-stage redirect.
// Defining BPU_STATS_EN builds saturating resolved/mispredict counters; otherwise they read 0.
module branch_predict_unit #(
    parameter int         INDEX_BITS = 6,
    parameter int         TAG_BITS   = 12,
    parameter logic [1:0] CNT_INIT   = 2'b01
) (
    input logic  clk,
    input logic  rst,
    bpu_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [63:0]           target_q [ENTRIES];
    logic [1:0]            cnt_q    [ENTRIES];
    logic [INDEX_BITS-1:0] if_idx, id_idx;
    logic [TAG_BITS-1:0]   if_tag, id_tag;
    logic                  if_hit, id_hit, res, act_taken, mis;
    logic [1:0]            cnt_d;
    logic                  unused_bits;
    assign if_idx = bus.if_pc[INDEX_BITS+1:2];
    assign if_tag = bus.if_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign id_idx = bus.id_pc[INDEX_BITS+1:2];
    assign id_tag = bus.id_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign unused_bits = ^{bus.if_pc[63:INDEX_BITS+TAG_BITS+2], bus.if_pc[1:0]};
    assign if_hit = valid_q[if_idx] && tag_q[if_idx] == if_tag;
    assign id_hit = valid_q[id_idx] && tag_q[id_idx] == id_tag;
    assign bus.pred_taken  = if_hit && cnt_q[if_idx][1];
    assign bus.pred_target = if_hit ? target_q[if_idx] : '0;
    assign res       = bus.id_valid && !bus.id_stall && (bus.id_is_branch || bus.id_is_jal);
    assign act_taken = bus.id_is_jal || bus.br_taken;
    assign mis = res && ((act_taken != bus.id_pred_taken) ||
                         (act_taken && bus.id_pred_target != bus.br_target));
    assign bus.redirect    = mis && !rst;
    assign bus.redirect_pc = rst ? '0 : act_taken ? bus.br_target : bus.id_pc + 64'd4;
    // A tag miss reallocates the entry with a weak counter in the resolved direction.
    always_comb begin
        cnt_d = act_taken ? 2'b10 : 2'b01;
        if (id_hit)
            cnt_d = act_taken ? (cnt_q[id_idx] == 2'b11 ? 2'b11 : cnt_q[id_idx] + 2'd1)
                              : (cnt_q[id_idx] == 2'b00 ? 2'b00 : cnt_q[id_idx] - 2'd1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
        end else if (res) begin
            valid_q[id_idx] <= 1'b1;
            cnt_q[id_idx]   <= cnt_d;
        end
    end
    // Tag and target are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (res && !rst) begin
            tag_q[id_idx]    <= id_tag;
            target_q[id_idx] <= bus.br_target;
        end
    end
`ifdef BPU_STATS_EN
    logic [31:0] br_cnt_q, mis_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (res && br_cnt_q != '1) br_cnt_q <= br_cnt_q + 32'd1;
            if (mis && mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 32'd1;
        end
    end
    assign bus.br_count      = br_cnt_q;
    assign bus.mispred_count = mis_cnt_q;
`else
    assign bus.br_count      = '0;
    assign bus.mispred_count = '0;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed vectors for branch_predict_unit with hand-computed expectations.
module tb_branch_predict_unit;
`ifdef BPU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic clk, rst;
    int n_vec, n_err;
    bpu_if u_bus ();
    branch_predict_unit dut (.clk(clk), .rst(rst), .bus(u_bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [63:0] st(input logic [63:0] n);
        return STATS ? n : 64'd0;
    endfunction
    task automatic resolve(input logic [63:0] pc, input logic is_br, input logic is_jal,
                           input logic ptaken, input logic [63:0] ptgt,
                           input logic taken, input logic [63:0] tgt);
        u_bus.id_valid = 1'b1;
        u_bus.id_stall = 1'b0;
        u_bus.id_is_branch = is_br;
        u_bus.id_is_jal = is_jal;
        u_bus.id_pc = pc;
        u_bus.id_pred_taken = ptaken;
        u_bus.id_pred_target = ptgt;
        u_bus.br_taken = taken;
        u_bus.br_target = tgt;
    endtask
    task automatic idle();
        u_bus.id_valid = 1'b0;
        u_bus.id_stall = 1'b0;
        u_bus.id_is_branch = 1'b0;
        u_bus.id_is_jal = 1'b0;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        u_bus.if_pc = 64'h1000;
        resolve(64'h1000, 1, 0, 0, 64'h0, 1, 64'h1040);
        #2;
        chk("rst_redirect", u_bus.redirect, 0);
        chk("rst_redirect_pc", u_bus.redirect_pc, 0);
        chk("rst_pred_taken", u_bus.pred_taken, 0);
        chk("rst_pred_target", u_bus.pred_target, 0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("init_pred_taken", u_bus.pred_taken, 0);
        chk("init_pred_target", u_bus.pred_target, 0);
        chk("init_redirect", u_bus.redirect, 0);
        chk("init_br_count", u_bus.br_count, 0);
        chk("init_mis_count", u_bus.mispred_count, 0);
        resolve(64'h1000, 1, 0, 0, 64'h0, 1, 64'h1040);
        #1;
        chk("tk_redirect", u_bus.redirect, 1);
        chk("tk_redirect_pc", u_bus.redirect_pc, 64'h1040);
        chk("tk_same_cycle_old", u_bus.pred_taken, 0);
        tick();
        idle();
        #1;
        chk("tk_pred_taken", u_bus.pred_taken, 1);
        chk("tk_pred_target", u_bus.pred_target, 64'h1040);
        resolve(64'h1000, 1, 0, 1, 64'h1040, 0, 64'h1040);
        #1;
        chk("nt1_redirect", u_bus.redirect, 1);
        chk("nt1_redirect_pc", u_bus.redirect_pc, 64'h1004);
        tick();
        idle();
        #1;
        chk("nt1_pred_taken", u_bus.pred_taken, 0);
        resolve(64'h1000, 1, 0, 0, 64'h0, 0, 64'h1040);
        #1;
        chk("nt2_redirect", u_bus.redirect, 0);
        tick();
        resolve(64'h1000, 1, 0, 0, 64'h0, 1, 64'h1040);
        #1;
        chk("sat_redirect", u_bus.redirect, 1);
        tick();
        idle();
        #1;
        chk("sat_pred_taken", u_bus.pred_taken, 0);
        resolve(64'h1000, 1, 0, 0, 64'h0, 1, 64'h1040);
        u_bus.id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_redirect", u_bus.redirect, 0);
            tick();
        end
        chk("stall_no_update", u_bus.pred_taken, 0);
        chk("stall_br_count", u_bus.br_count, st(4));
        u_bus.id_stall = 1'b0;
        #1;
        chk("unstall_redirect", u_bus.redirect, 1);
        chk("unstall_redirect_pc", u_bus.redirect_pc, 64'h1040);
        tick();
        idle();
        #1;
        chk("unstall_once", u_bus.redirect, 0);
        chk("unstall_pred_taken", u_bus.pred_taken, 1);
        chk("unstall_br_count", u_bus.br_count, st(5));
        chk("unstall_mis_count", u_bus.mispred_count, st(4));
        u_bus.if_pc = 64'h2000;
        resolve(64'h2000, 1, 1, 0, 64'h0, 0, 64'h2100);
        #1;
        chk("jal_redirect", u_bus.redirect, 1);
        chk("jal_redirect_pc", u_bus.redirect_pc, 64'h2100);
        tick();
        idle();
        #1;
        chk("jal_pred_taken", u_bus.pred_taken, 1);
        chk("jal_pred_target", u_bus.pred_target, 64'h2100);
        resolve(64'h2000, 0, 1, 1, 64'h2100, 0, 64'h2200);
        #1;
        chk("tgt_mis_redirect", u_bus.redirect, 1);
        chk("tgt_mis_redirect_pc", u_bus.redirect_pc, 64'h2200);
        tick();
        resolve(64'h2000, 0, 1, 1, 64'h2200, 0, 64'h2200);
        #1;
        chk("tgt_ok_redirect", u_bus.redirect, 0);
        chk("tgt_ok_pred_target", u_bus.pred_target, 64'h2200);
        tick();
        u_bus.if_pc = 64'h1000;
        resolve(64'h1100, 1, 0, 0, 64'h0, 0, 64'h1180);
        #1;
        chk("alias_redirect", u_bus.redirect, 0);
        tick();
        idle();
        #1;
        chk("alias_old_taken", u_bus.pred_taken, 0);
        chk("alias_old_target", u_bus.pred_target, 0);
        u_bus.if_pc = 64'h1100;
        #1;
        chk("alias_new_taken", u_bus.pred_taken, 0);
        chk("alias_new_target", u_bus.pred_target, 64'h1180);
        u_bus.if_pc = 64'h1102;
        #1;
        chk("low_bits_ignored", u_bus.pred_target, 64'h1180);
        chk("pre_rst_br_count", u_bus.br_count, st(9));
        chk("pre_rst_mis_count", u_bus.mispred_count, st(6));
        u_bus.if_pc = 64'h3000;
        resolve(64'h3000, 1, 0, 0, 64'h0, 1, 64'h3040);
        #1;
        chk("mid_rst_res", u_bus.redirect, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_redirect", u_bus.redirect, 0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("post_rst_3000", u_bus.pred_target, 0);
        u_bus.if_pc = 64'h2000;
        #1;
        chk("post_rst_2000_taken", u_bus.pred_taken, 0);
        chk("post_rst_2000_target", u_bus.pred_target, 0);
        u_bus.if_pc = 64'h1100;
        #1;
        chk("post_rst_1100", u_bus.pred_target, 0);
        chk("post_rst_br_count", u_bus.br_count, 0);
        chk("post_rst_mis_count", u_bus.mispred_count, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Dynamic branch predictor and PC-redirect block for the 5-stage RV64 core.
- IF side: looks up the fetch PC and supplies a predicted direction and target.
- ID side: consumes the branch comparator's resolved br_taken plus the computed target. It detects mispredictions, issues a redirect/flush, and trains a table of 2-bit saturating counters with a tagged BTB.

Parameters:
- INDEX_BITS, 6, log2 of table entries (default 64 entries); index = pc[INDEX_BITS+1:2].
- TAG_BITS, 12, stored tag width; tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
- CNT_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_pc  input  64  fetch PC being looked up.
- pred_taken  output  1  predicted taken for if_pc.
- pred_target  output  64  predicted target for if_pc; valid when pred_taken=1.
- id_valid  input  1  ID stage holds a real instruction.
- id_stall  input  1  ID stage stalled (load-use hazard); resolution is not final.
- id_is_branch  input  1  ID instruction is a conditional branch.
- id_is_jal  input  1  ID instruction is JAL; always taken.
- id_pc  input  64  PC of ID instruction.
- id_pred_taken  input  1  prediction that was piped along with the ID instruction.
- id_pred_target  input  64  predicted target piped along with the ID instruction.
- br_taken  input  1  resolved direction from the branch comparator.
- br_target  input  64  resolved target (id_pc + imm).
- redirect  output  1  mispredict; the fetch PC must load redirect_pc and IF must be flushed.
- redirect_pc  output  64  correct next PC.
- br_count  output  32  resolved control-transfer count (see Optional Feature).
- mispred_count  output  32  mispredict count (see Optional Feature).

Behaviour:
- Storage per entry: valid (1), tag (TAG_BITS), target (64), counter (2).
- Reset (async, rst=1): all valid=0, all counters=CNT_INIT, stats counters=0.
  - Outputs during reset: pred_taken=0, pred_target=0, redirect=0, redirect_pc=0.
  - Reset asserted mid-update: the update is lost; the table is fully cleared.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && counter[1].
  - pred_target = target[idx] when hit, else 0.
- Resolution qualifier: res = id_valid && !id_stall && (id_is_branch || id_is_jal).
  - No redirect, update or count while id_stall=1; the same instruction resolves on the first unstalled cycle.
- Actual outcome: act_taken = id_is_jal ? 1 : br_taken.
- Mispredict (combinational, same cycle as res): mis = res && ((act_taken != id_pred_taken) || (act_taken && id_pred_target != br_target)).
  - redirect = mis.
  - redirect_pc = act_taken ? br_target : id_pc + 4.
  - If both id_is_branch and id_is_jal are set, id_is_jal has priority.
- Update (registered; visible to lookups from the next cycle):
  - On res, the entry at id_pc's index takes: valid=1, tag=id_pc tag, target=br_target.
  - Counter training:
    - If the tag matched before the update, the counter saturates up on act_taken and down otherwise (3 stays 3, 0 stays 0).
    - If the tag missed, the entry is (re)allocated with counter = act_taken ? 2'b10 : 2'b01.
  - JAL always trains toward taken.
- Same-index lookup and update in one cycle: the lookup returns the pre-update (old) contents.
- Not-taken branch that misses the table: the entry is still allocated (counter 01). pred_taken stays 0 for that PC until the counter reaches 2.
- Address bits pc[1:0] are ignored for index and tag.

Optional Feature:
- Macro: BPU_STATS_EN.
- Defined:
  - br_count increments on every res.
  - mispred_count increments on every mis.
  - Both are 32-bit and saturate at 32'hFFFF_FFFF.
  - Both clear on rst.
- Undefined: no counter flops are built; br_count and mispred_count are tied to 0.

Test Plan:
- Reset then lookup if_pc=64'h1000 -> pred_taken=0, pred_target=0, redirect=0.
- Branch at id_pc=64'h1000, id_pred_taken=0, br_taken=1, br_target=64'h1040 -> same-cycle redirect=1, redirect_pc=64'h1040.
  - Next cycle, lookup 64'h1000 -> pred_taken=1, pred_target=64'h1040 (counter 10).
- Same branch resolved not-taken twice with matching prediction inputs:
  - First resolution: counter 10->01, redirect_pc=64'h1004 only on the mispredicted resolution.
  - Second resolution: counter saturates at 00; lookup returns pred_taken=0.
- id_stall=1 for 3 cycles with a mispredicting branch -> redirect=0 and no table change during the stall.
  - First cycle after id_stall=0: redirect=1 exactly once; br_count +1 (BPU_STATS_EN).
- Aliasing: train 64'h1000 taken, then resolve 64'h1000+(64<<2) with a different tag -> entry reallocated.
  - Lookup 64'h1000 -> pred_taken=0.
- Assert rst during a cycle with res=1 -> all lookups miss afterwards; stats counters read 0.
